// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: parses a byte stream (16-bit word count,
// little-endian 32-bit words, 8-bit additive checksum), writes each word into
// instruction memory, and holds the CPU in reset until a good load completes.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              fun_clk,
    input  logic              fun_rst,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Largest legal word count; 17 bits so that 2^16 is representable.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [15:0]       n_full;
    logic              last_word;

    // Write port is registered so address/data hold after the strobe drops.
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge fun_clk) begin
        if (fun_rst) begin
            state_q <= LEN0;
            n_q     <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            bcnt_q  <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        bcnt_d     = bcnt_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_rst    = 1'b1;
        load_done  = 1'b0;
        load_err   = 1'b0;
        n_full     = {byte_data, n_q[7:0]};
        last_word  = (32'(idx_q) == (32'(n_q) - 32'd1));

        case (state_q)
            LEN0: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    n_d[7:0] = byte_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    n_d[15:8] = byte_data;
                    if ({1'b0, n_full} > CAPACITY) begin
                        state_d = ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    // Bytes enter at the top so byte 0 ends up in bits 7:0.
                    asm_d  = {byte_data, asm_q[31:8]};
                    sum_d  = sum_q + byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d  = idx_q;
                        wdata_d = {byte_data, asm_q[31:8]};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (last_word) begin
                    state_d = CSUM;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = DATA;
                end
            end
            CSUM: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_d = (byte_data == sum_q) ? DONE : ERR;
                end
            end
            DONE: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
            end
            ERR: begin
                load_err = 1'b1;
            end
            default: begin
                state_d = LEN0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a stream-level model predicts writes and the
// final outcome; a per-cycle monitor checks the DUT against it.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic              fun_clk = 1'b0;
    logic              fun_rst = 1'b1;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .fun_clk    (fun_clk),
        .fun_rst    (fun_rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 fun_clk = ~fun_clk;

    int total = 0;
    int bad   = 0;

    // Stream-level model state.
    logic [7:0]  strm[$];
    logic [31:0] exp_words[$];
    int          exp_len;
    int          exp_n;
    bit          exp_ok;
    int          consumed;
    int          writes_seen;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    bit          mon_en = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Derive the expected outcome of a whole stream from the format rules.
    task automatic set_model(input logic [7:0] s[$]);
        int   n;
        logic [7:0] sum;
        strm = s;
        exp_words.delete();
        n   = int'(s[0]) + 256 * int'(s[1]);
        sum = 8'h00;
        if (n > CAP) begin
            exp_n   = 0;
            exp_len = 2;
            exp_ok  = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_words.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
                sum = sum + s[2+4*i] + s[2+4*i+1] + s[2+4*i+2] + s[2+4*i+3];
            end
            exp_n   = n;
            exp_len = 3 + 4 * n;
            exp_ok  = (s[2+4*n] == sum);
        end
        consumed    = 0;
        writes_seen = 0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge fun_clk);
            if (mon_en) begin
                int avail;
                bit e_we;
                bit term;
                avail = 0;
                if (exp_n > 0 && consumed >= 2) begin
                    avail = (consumed - 2) / 4;
                    if (avail > exp_n) avail = exp_n;
                end
                e_we = (avail > writes_seen);
                term = (consumed == exp_len) && !e_we;
                chk1("imem_we", imem_we, e_we);
                chk1("byte_ready", byte_ready, !term && !e_we);
                chk1("load_done", load_done, term && exp_ok);
                chk1("load_err", load_err, term && !exp_ok);
                chk1("cpu_rst", cpu_rst, !(term && exp_ok));
                if (imem_we) begin
                    $display("write addr=%0d data=%h", imem_addr, imem_wdata);
                    if (writes_seen < exp_n) begin
                        chk32("write_addr", 32'(imem_addr), 32'(writes_seen));
                        chk32("write_data", imem_wdata, exp_words[writes_seen]);
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL extra_write: got write %0d want at most %0d", writes_seen + 1, exp_n);
                    end
                    last_addr = 32'(imem_addr);
                    last_data = imem_wdata;
                    writes_seen++;
                end else begin
                    chk32("addr_hold", 32'(imem_addr), last_addr);
                    chk32("wdata_hold", imem_wdata, last_data);
                end
                if (byte_valid && byte_ready) consumed++;
            end
        end
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge fun_clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        w = 0;
        while (!byte_ready && w < 40) begin
            @(posedge fun_clk);
            #1;
            w++;
        end
        if (w >= 40) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: byte_ready stayed %b want 1", byte_ready);
        end
        @(posedge fun_clk);
        #1;
    endtask

    task automatic send_stream(input int count, input int gap);
        for (int i = 0; i < count; i++) send_byte(strm[i], gap);
        byte_valid = 1'b0;
        repeat (3) begin
            @(posedge fun_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mon_en     = 1'b0;
        byte_valid = 1'b0;
        fun_rst    = 1'b1;
        repeat (2) begin
            @(posedge fun_clk);
            #1;
        end
        fun_rst   = 1'b0;
        last_addr = 32'h0;
        last_data = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        logic [7:0] sum;

        // Reset state.
        do_reset();
        chk1("rst_byte_ready", byte_ready, 1'b1);
        chk1("rst_cpu_rst", cpu_rst, 1'b1);
        chk1("rst_load_done", load_done, 1'b0);
        chk1("rst_load_err", load_err, 1'b0);
        chk1("rst_imem_we", imem_we, 1'b0);
        chk32("rst_addr", 32'(imem_addr), 32'h0);
        chk32("rst_wdata", imem_wdata, 32'h0);

        // One word, good checksum, with gaps in byte_valid.
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
        set_model(s);
        mon_en = 1'b1;
        send_stream(7, 2);
        chk32("one_word_count", 32'(writes_seen), 32'd1);
        chk32("one_word_data", last_data, 32'h00A00513);
        chk1("one_word_done", load_done, 1'b1);
        chk1("one_word_cpu_rst", cpu_rst, 1'b0);

        // Empty load.
        do_reset();
        s = '{8'h00, 8'h00, 8'h00};
        set_model(s);
        mon_en = 1'b1;
        send_stream(3, 1);
        chk32("empty_count", 32'(writes_seen), 32'd0);
        chk1("empty_done", load_done, 1'b1);
        chk1("empty_cpu_rst", cpu_rst, 1'b0);

        // Bad checksum after one written word.
        do_reset();
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
        set_model(s);
        mon_en = 1'b1;
        send_stream(7, 0);
        chk32("badsum_count", 32'(writes_seen), 32'd1);
        chk32("badsum_data", last_data, 32'h00A00513);
        chk1("badsum_err", load_err, 1'b1);
        chk1("badsum_cpu_rst", cpu_rst, 1'b1);
        chk1("badsum_done", load_done, 1'b0);

        // Length one beyond capacity.
        do_reset();
        s = '{8'h01, 8'h01};
        set_model(s);
        mon_en = 1'b1;
        send_stream(2, 0);
        chk32("len_err_count", 32'(writes_seen), 32'd0);
        chk1("len_err_err", load_err, 1'b1);
        chk1("len_err_ready", byte_ready, 1'b0);

        // Two words with byte_valid held high throughout.
        do_reset();
        s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        set_model(s);
        mon_en = 1'b1;
        send_stream(11, 0);
        chk32("two_word_count", 32'(writes_seen), 32'd2);
        chk32("two_word_last", last_data, 32'h88776655);
        chk32("two_word_addr", last_addr, 32'd1);
        chk1("two_word_done", load_done, 1'b1);

        // Reset after two data bytes, then a fresh stream.
        do_reset();
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
        set_model(s);
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(strm[i], 0);
        do_reset();
        chk1("midrst_we", imem_we, 1'b0);
        chk32("midrst_addr", 32'(imem_addr), 32'h0);
        chk32("midrst_wdata", imem_wdata, 32'h0);
        chk1("midrst_ready", byte_ready, 1'b1);
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        set_model(s);
        mon_en = 1'b1;
        send_stream(7, 1);
        chk32("midrst_count", 32'(writes_seen), 32'd1);
        chk32("midrst_data", last_data, 32'hDEADBEEF);
        chk1("midrst_done", load_done, 1'b1);

        // Full capacity load (N = 2^ADDR_W).
        do_reset();
        s.delete();
        s.push_back(8'h00);
        s.push_back(8'h01);
        sum = 8'h00;
        for (int j = 0; j < 4 * CAP; j++) begin
            s.push_back(8'(j * 7 + 3));
            sum = sum + 8'(j * 7 + 3);
        end
        s.push_back(sum);
        set_model(s);
        mon_en = 1'b1;
        send_stream(s.size(), 0);
        chk32("full_count", 32'(writes_seen), 32'd256);
        chk32("full_last_addr", last_addr, 32'd255);
        chk32("full_last_data", last_data, 32'hFCF5EEE7);
        chk1("full_done", load_done, 1'b1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
